// File: rtl/tank_pkg.sv
// Shared types and screen/tank geometry for the tank game, plus the bullet
// spawn helper used by the bullet engine.
package tank_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned TANK_SIZE = 32;
  localparam int unsigned TILE_SIZE = 32;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_IMPACT = 2'd2,
    ST_RELOAD = 2'd3
  } bullet_state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       oob;
  } spawn_t;

  // Bullet is centred on the tank edge it leaves from; oob flags underflow or off-screen.
  function automatic spawn_t bullet_spawn(input logic [9:0]  tx,
                                          input logic [9:0]  ty,
                                          input dir_e        d,
                                          input logic [10:0] bsize);
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] sx;
    logic [10:0] sy;
    logic [10:0] centre;
    logic [10:0] tank;
    logic        under;
    spawn_t      res;
    x11    = {1'b0, tx};
    y11    = {1'b0, ty};
    tank   = 11'(TANK_SIZE);
    centre = (tank - bsize) >> 1;
    sx     = x11;
    sy     = y11;
    under  = 1'b0;
    case (d)
      DIR_UP: begin
        sx    = x11 + centre;
        sy    = y11 - bsize;
        under = (y11 < bsize);
      end
      DIR_DOWN: begin
        sx = x11 + centre;
        sy = y11 + tank;
      end
      DIR_LEFT: begin
        sx    = x11 - bsize;
        sy    = y11 + centre;
        under = (x11 < bsize);
      end
      DIR_RIGHT: begin
        sx = x11 + tank;
        sy = y11 + centre;
      end
      default: begin
        under = 1'b1;
      end
    endcase
    res.x   = sx[9:0];
    res.y   = sy[9:0];
    res.oob = under || (sx > (11'(H_ACTIVE) - bsize)) || (sy > (11'(V_ACTIVE) - bsize));
    return res;
  endfunction

endpackage

// File: rtl/bullet_box_hit.sv
// Square-box membership test for a pixel; shared by bullet and sprite logic.
// Sums are 11 bits wide so a box touching the right/bottom edge never wraps.
module bullet_box_hit (
  input  logic [9:0]  bx,
  input  logic [9:0]  by,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic [10:0] size,
  output logic        in_box
);

  logic [10:0] h11_s;
  logic [10:0] v11_s;
  logic [10:0] bx11_s;
  logic [10:0] by11_s;

  assign h11_s  = {1'b0, hpos};
  assign v11_s  = {1'b0, vpos};
  assign bx11_s = {1'b0, bx};
  assign by11_s = {1'b0, by};

  assign in_box = (h11_s >= bx11_s) && (h11_s < (bx11_s + size)) &&
                  (v11_s >= by11_s) && (v11_s < (by11_s + size));

endmodule

// File: rtl/bullet_ctrl.sv
// Single-bullet engine for one tank: spawn, per-frame motion, hard-block hit
// detection during the scan, one-frame map clear strobe, and reload cooldown.
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter int unsigned BULLET_SIZE     = 4,
  parameter int unsigned SPEED           = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       display_enable_i,
  input  logic [9:0] hpos_i,
  input  logic [9:0] vpos_i,
  input  logic       all_hard_block_i,
  input  logic       fire_i,
  input  logic [9:0] tank_x_i,
  input  logic [9:0] tank_y_i,
  input  logic [1:0] tank_dir_i,
  output logic       bullet_pixel_o,
  output logic       bullet_collide_o,
  output logic       bullet_active_o
);

  localparam int unsigned CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [10:0] SIZE_C  = 11'(BULLET_SIZE);
  localparam logic [10:0] SPEED_C = 11'(SPEED);
  localparam logic [10:0] X_MAX_C = 11'(H_ACTIVE - BULLET_SIZE);
  localparam logic [10:0] Y_MAX_C = 11'(V_ACTIVE - BULLET_SIZE);
  localparam logic [CNT_W-1:0] COOL_LOAD_C = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_ZERO_C = CNT_W'(0);

  bullet_state_e    state_r, state_s;
  logic [9:0]       bx_r, bx_s;
  logic [9:0]       by_r, by_s;
  dir_e             dir_r, dir_s;
  logic             hit_flag_r, hit_flag_s;
  logic [CNT_W-1:0] cool_cnt_r, cool_cnt_s;

  logic             frame_end_s;
  logic             box_hit_s;
  logic             in_box_s;
  logic             hit_now_s;
  spawn_t           spawn_s;
  logic [10:0]      mv_x_s;
  logic [10:0]      mv_y_s;
  logic             mv_oob_s;

  bullet_box_hit u_box (
    .bx     (bx_r),
    .by     (by_r),
    .hpos   (hpos_i),
    .vpos   (vpos_i),
    .size   (SIZE_C),
    .in_box (box_hit_s)
  );

  assign frame_end_s = display_enable_i && (hpos_i == 10'(H_ACTIVE - 1)) &&
                       (vpos_i == 10'(V_ACTIVE - 1));
  assign in_box_s    = display_enable_i && box_hit_s;
  assign hit_now_s   = in_box_s && all_hard_block_i;
  assign spawn_s     = bullet_spawn(tank_x_i, tank_y_i, dir_e'(tank_dir_i), SIZE_C);

  // Candidate position one step along the latched direction, with bounds check.
  always_comb begin
    mv_x_s   = {1'b0, bx_r};
    mv_y_s   = {1'b0, by_r};
    mv_oob_s = 1'b0;
    case (dir_r)
      DIR_UP: begin
        mv_y_s   = {1'b0, by_r} - SPEED_C;
        mv_oob_s = ({1'b0, by_r} < SPEED_C);
      end
      DIR_DOWN:  mv_y_s = {1'b0, by_r} + SPEED_C;
      DIR_LEFT: begin
        mv_x_s   = {1'b0, bx_r} - SPEED_C;
        mv_oob_s = ({1'b0, bx_r} < SPEED_C);
      end
      DIR_RIGHT: mv_x_s = {1'b0, bx_r} + SPEED_C;
      default:   mv_oob_s = 1'b1;
    endcase
    mv_oob_s = mv_oob_s || (mv_x_s > X_MAX_C) || (mv_y_s > Y_MAX_C);
  end

  // Next-state and datapath updates for the bullet FSM.
  always_comb begin
    state_s    = state_r;
    bx_s       = bx_r;
    by_s       = by_r;
    dir_s      = dir_r;
    hit_flag_s = hit_flag_r;
    cool_cnt_s = cool_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (fire_i) begin
          dir_s      = dir_e'(tank_dir_i);
          hit_flag_s = 1'b0;
          if (spawn_s.oob) begin
            state_s    = ST_RELOAD;
            cool_cnt_s = COOL_LOAD_C;
          end else begin
            state_s = ST_FLYING;
            bx_s    = spawn_s.x;
            by_s    = spawn_s.y;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FLYING: begin
        if (frame_end_s) begin
          hit_flag_s = 1'b0;
          if (hit_flag_r || hit_now_s) begin
            state_s = ST_IMPACT;
          end else if (mv_oob_s) begin
            state_s    = ST_RELOAD;
            cool_cnt_s = COOL_LOAD_C;
          end else begin
            bx_s = mv_x_s[9:0];
            by_s = mv_y_s[9:0];
          end
        end else begin
          hit_flag_s = hit_flag_r || hit_now_s;
        end
      end
      ST_IMPACT: begin
        if (frame_end_s) begin
          state_s    = ST_RELOAD;
          cool_cnt_s = COOL_LOAD_C;
        end else begin
          state_s = ST_IMPACT;
        end
      end
      ST_RELOAD: begin
        if (frame_end_s) begin
          if (cool_cnt_r == COOL_ZERO_C) begin
            state_s = ST_IDLE;
          end else begin
            cool_cnt_s = cool_cnt_r - CNT_W'(1);
          end
        end else begin
          state_s = ST_RELOAD;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r    <= ST_IDLE;
      bx_r       <= 10'd0;
      by_r       <= 10'd0;
      dir_r      <= DIR_UP;
      hit_flag_r <= 1'b0;
      cool_cnt_r <= COOL_ZERO_C;
    end else begin
      state_r    <= state_s;
      bx_r       <= bx_s;
      by_r       <= by_s;
      dir_r      <= dir_s;
      hit_flag_r <= hit_flag_s;
      cool_cnt_r <= cool_cnt_s;
    end
  end

  // Outputs follow the live scan position so the map strobe has zero latency.
  assign bullet_pixel_o   = (state_r == ST_FLYING) && in_box_s;
  assign bullet_collide_o = (state_r == ST_IMPACT) && in_box_s;
  assign bullet_active_o  = (state_r != ST_IDLE);

endmodule
